// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC sequencer bundle: fetch requests in, program-counter state out.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                  Halt;
  logic                  Resume;
  logic                  Stall;
  logic                  MuxBranch;
  logic                  JumpContext;
  logic                  ReturnContext;
  logic [31:0]           Imediato;
  logic [ADDR_WIDTH-1:0] PCAtual;
  logic [ADDR_WIDTH-1:0] Base;
  logic [ADDR_WIDTH-1:0] SavedPC;
  logic                  Flush;
  logic [1:0]            Estado;

  modport master (
    output Halt, Resume, Stall, MuxBranch, JumpContext, ReturnContext, Imediato,
    input  PCAtual, Base, SavedPC, Flush, Estado
  );

  modport slave (
    input  Halt, Resume, Stall, MuxBranch, JumpContext, ReturnContext, Imediato,
    output PCAtual, Base, SavedPC, Flush, Estado
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: resolves next fetch address, context base/return PC,
// post-switch flush window and halt/resume.
module pc_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned RESET_ADDR   = 0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic            clock,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    HALTED  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] saved_q, saved_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] imm;
  logic                  unused_imm_high;

  // Only the low address bits of the immediate carry a target or base.
  assign imm             = bus.Imediato[ADDR_WIDTH-1:0];
  assign unused_imm_high = ^bus.Imediato[31:ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= ADDR_WIDTH'(RESET_ADDR);
      base_q  <= '0;
      saved_q <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    base_d  = base_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (bus.Halt) begin
          state_d = HALTED;
        end else if (bus.JumpContext) begin
          saved_d = pc_q + ADDR_WIDTH'(1);
          base_d  = imm;
          pc_d    = imm;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
          state_d = FLUSH;
        end else if (bus.ReturnContext) begin
          pc_d    = saved_q;
          base_d  = '0;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
          state_d = FLUSH;
        end else if (bus.MuxBranch) begin
          pc_d = imm + base_q;
        end else if (!bus.Stall) begin
          pc_d = pc_q + ADDR_WIDTH'(1);
        end
      end
      FLUSH: begin
        // Leave on the edge where the last flush cycle ends; a zero count cannot trap us here.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HALTED: begin
        if (bus.Resume) begin
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    flush_d = (state_d == FLUSH);
  end

  assign bus.PCAtual = pc_q;
  assign bus.Base    = base_q;
  assign bus.SavedPC = saved_q;
  assign bus.Flush   = flush_q;
  assign bus.Estado  = 2'(state_q);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against an abstract model.
module tb_pc_sequencer;

  localparam int unsigned AW    = 11;
  localparam int          MOD   = 2048;
  localparam int          FLUSH = 2;

  logic clock;
  logic reset;

  pc_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  pc_sequencer #(.ADDR_WIDTH(AW), .RESET_ADDR(0), .FLUSH_CYCLES(FLUSH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  // Reference: an address, a base, a return address, a halted flag and flush cycles left.
  int m_pc, m_base, m_saved, m_flush_left;
  bit m_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int est;
    est = m_halted ? 2 : (m_flush_left > 0 ? 1 : 0);
    check({tag, ".pc"},     32'(bus.PCAtual), 32'(m_pc));
    check({tag, ".base"},   32'(bus.Base),    32'(m_base));
    check({tag, ".saved"},  32'(bus.SavedPC), 32'(m_saved));
    check({tag, ".flush"},  32'(bus.Flush),   32'(m_flush_left > 0));
    check({tag, ".estado"}, 32'(bus.Estado),  32'(est));
  endtask

  task automatic model(input bit rst, h, rs, st, br, jc, rc, input logic [31:0] imm);
    int a;
    a = int'(imm % 32'(MOD));
    if (rst) begin
      m_pc = 0; m_base = 0; m_saved = 0; m_flush_left = 0; m_halted = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_halted) begin
      if (rs) begin
        m_pc = (m_pc + 1) % MOD;
        m_halted = 0;
      end
    end else if (h) begin
      m_halted = 1;
    end else if (jc) begin
      m_saved = (m_pc + 1) % MOD;
      m_base = a;
      m_pc = a;
      m_flush_left = FLUSH;
    end else if (rc) begin
      m_pc = m_saved;
      m_base = 0;
      m_flush_left = FLUSH;
    end else if (br) begin
      m_pc = (a + m_base) % MOD;
    end else if (!st) begin
      m_pc = (m_pc + 1) % MOD;
    end
  endtask

  task automatic step(input string tag, input bit rst, h, rs, st, br, jc, rc,
                      input logic [31:0] imm);
    @(negedge clock);
    reset = rst; bus.Halt = h; bus.Resume = rs; bus.Stall = st;
    bus.MuxBranch = br; bus.JumpContext = jc; bus.ReturnContext = rc; bus.Imediato = imm;
    @(posedge clock);
    model(rst, h, rs, st, br, jc, rc, imm);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic branch(input string tag, input logic [31:0] imm);
    step(tag, 0, 0, 0, 0, 1, 0, 0, imm);
  endtask

  initial begin
    reset = 1'b1;
    bus.Halt = 0; bus.Resume = 0; bus.Stall = 0; bus.MuxBranch = 0;
    bus.JumpContext = 0; bus.ReturnContext = 0; bus.Imediato = '0;
    m_pc = 0; m_base = 0; m_saved = 0; m_flush_left = 0; m_halted = 0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0, 32'h0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 32'h0);
    check("reset_pc", 32'(bus.PCAtual), 32'd0);
    idle("inc", 5);
    check("inc_pc5", 32'(bus.PCAtual), 32'd5);
    idle("inc", 5);

    // Branch at PC=10 then a 3-cycle stall.
    step("br200", 0, 0, 0, 0, 1, 0, 0, 32'h0000_00C8);
    check("br200_lit", 32'(bus.PCAtual), 32'd200);
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 1, 0, 0, 0, 32'h0);
    idle("post_stall", 1);
    check("post_stall_lit", 32'(bus.PCAtual), 32'd201);

    // Context entry from PC=20, then a relocated branch.
    branch("br20", 32'd20);
    step("jump", 0, 0, 0, 0, 0, 1, 0, 32'h400);
    check("jump_saved_lit", 32'(bus.SavedPC), 32'd21);
    idle("jflush", 2);
    branch("reloc", 32'd5);
    check("reloc_lit", 32'(bus.PCAtual), 32'd1029);

    // Return; a branch pulse inside the flush window must be dropped.
    step("ret", 0, 0, 0, 0, 0, 0, 1, 32'h0);
    branch("ret_flush_br", 32'd77);
    idle("ret_flush", 1);
    check("ret_pc_lit", 32'(bus.PCAtual), 32'd21);

    // Wrap of the increment and of base+target.
    branch("br2047", 32'd2047);
    idle("wrap", 1);
    check("wrap_lit", 32'(bus.PCAtual), 32'd0);
    step("jump2000", 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_F7D0);
    idle("j2k_flush", 2);
    branch("br_wrap", 32'd100);
    check("br_wrap_lit", 32'(bus.PCAtual), 32'd52);
    step("jump_nested", 0, 0, 0, 0, 0, 1, 0, 32'd600);
    idle("jn_flush", 2);
    step("ret2", 0, 0, 0, 0, 0, 0, 1, 32'h0);
    idle("ret2_flush", 2);
    step("ret_base0", 0, 0, 0, 0, 0, 0, 1, 32'h0);
    idle("rb0_flush", 2);

    // Halt at 30, noise while halted, resume.
    branch("br30", 32'd30);
    step("halt", 0, 1, 0, 0, 1, 0, 0, 32'd9);
    step("h_stall", 0, 0, 0, 1, 0, 0, 0, 32'h0);
    step("h_br", 0, 0, 0, 0, 1, 0, 0, 32'd3);
    step("h_jc", 0, 0, 0, 0, 0, 1, 0, 32'd3);
    step("h_idle", 0, 0, 0, 0, 0, 0, 0, 32'h0);
    step("resume", 0, 0, 1, 0, 0, 0, 0, 32'h0);
    check("resume_lit", 32'(bus.PCAtual), 32'd31);
    step("run_resume", 0, 0, 1, 0, 0, 0, 0, 32'h0);

    // Reset in the middle of a flush window.
    step("jump_rst", 0, 0, 0, 0, 0, 1, 0, 32'd500);
    step("rst_flush", 1, 0, 0, 0, 0, 0, 0, 32'h0);
    idle("after_rst", 2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit rst, h, rs, st, br, jc, rc;
      rst = ($urandom_range(0, 99) < 2);
      h   = ($urandom_range(0, 99) < 6);
      rs  = ($urandom_range(0, 99) < 25);
      st  = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 15);
      jc  = ($urandom_range(0, 99) < 5);
      rc  = ($urandom_range(0, 99) < 5);
      step($sformatf("rnd%0d", i), rst, h, rs, st, br, jc, rc, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch.
- Resolves next-PC each cycle from increment, branch/jump, context switch, context return, halt and stall.
- Maintains the per-context base offset and the saved kernel PC; branch targets are relocated by the active base.
- Sits between the control unit and instruction memory, replacing the purely combinational next-address selection.

Parameters:
- ADDR_WIDTH, 11, width of PC, base and saved-PC registers.
- RESET_ADDR, 0, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles the sequencer stays in FLUSH after a context switch or return (range 1-7).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Halt  input  1  halt instruction decoded this cycle.
- Resume  input  1  external resume request; only meaningful in HALTED.
- Stall  input  1  hold PC this cycle (data hazard or memory wait).
- MuxBranch  input  1  branch/jump taken; target is in Imediato.
- JumpContext  input  1  enter user context; Imediato[10:0] gives the new base.
- ReturnContext  input  1  return to kernel context.
- Imediato  input  32  target or base; only bits [ADDR_WIDTH-1:0] are used, the rest are ignored.
- PCAtual  output  ADDR_WIDTH  current fetch address (registered).
- Base  output  ADDR_WIDTH  active context base offset (registered).
- SavedPC  output  ADDR_WIDTH  kernel return address (registered).
- Flush  output  1  high while in FLUSH; the pipeline discards in-flight instructions.
- Estado  output  2  state encoding: RUN=0, FLUSH=1, HALTED=2.

Behaviour:
- Reset is synchronous. On reset: PCAtual=RESET_ADDR, Base=0, SavedPC=0, flush counter=0, Estado=RUN, Flush=0. Reset overrides all other inputs, in any state.
- All outputs are registered. A decision made in cycle N appears on the outputs after edge N+1.
- RUN state: the inputs are priority-resolved as follows (highest first).
  - Halt: PC held; go to HALTED.
  - JumpContext: SavedPC <= PCAtual+1; Base <= Imediato[10:0]; PC <= Imediato[10:0]; load counter = FLUSH_CYCLES; go to FLUSH.
  - ReturnContext: PC <= SavedPC; Base <= 0; SavedPC unchanged; load counter; go to FLUSH.
  - MuxBranch: PC <= (Imediato[10:0] + Base) mod 2^ADDR_WIDTH.
  - Stall: PC held.
  - Otherwise: PC <= PCAtual+1.
- FLUSH state: PC, Base and SavedPC are held. Flush=1. The counter decrements each cycle; when the counter equals 1, go to RUN on the next edge. The block stays in FLUSH for exactly FLUSH_CYCLES cycles. All request inputs and Stall are ignored.
- HALTED state: PC held. Flush=0. Resume=1 sets PC <= PCAtual+1 and goes to RUN. All other inputs are ignored. Resume is ignored in RUN and FLUSH.
- Arithmetic: all additions are modulo 2^ADDR_WIDTH, with no carry-out.
  - PC increment at 2047 wraps to 0.
  - Base + target overflow wraps.
- Simultaneous Halt and MuxBranch: Halt wins and the branch is lost. The control unit never asserts both.
- JumpContext while already in a user context (Base != 0): permitted. SavedPC is overwritten; there is no nesting.
- ReturnContext with Base=0: still restores SavedPC and flushes.
- Estado encoding 3 is illegal; if entered, the next edge goes to RUN with the PC held.

Test Plan:
- reset for 2 cycles, then 5 idle cycles -> PCAtual = 0,1,2,3,4,5; Flush=0; Estado=0.
- PCAtual=10, Base=0, MuxBranch=1, Imediato=0x000000C8 -> next PCAtual=200. Then with Stall=1 for 3 cycles -> PCAtual stays 200, then continues to 201.
- PCAtual=20, JumpContext=1, Imediato=0x400 -> PCAtual=1024, Base=1024, SavedPC=21, Flush=1 for exactly 2 cycles with PC held. Then MuxBranch with Imediato=5 -> PCAtual=1029.
- From the previous state, ReturnContext=1 -> PCAtual=21, Base=0, Flush=1 for 2 cycles. A MuxBranch pulse during FLUSH has no effect.
- PCAtual=2047, idle -> PCAtual=0. Base=2000 with MuxBranch Imediato=100 -> PCAtual=52 (wrap).
- Halt at PCAtual=30 -> Estado=2, PC held 30 across 4 cycles despite Stall/MuxBranch activity; Resume=1 -> PCAtual=31, Estado=0. A reset asserted during FLUSH -> PCAtual=0, Base=0, Flush=0 on the next edge.
